fan_drive_sequencer: RTL and testbench
======================================

FAN_DRIVE_SEQUENCER -- requirements
Module: fan_drive_sequencer

Interface
REQ-001 SHALL have parameter RAMP_STEP_TICKS, default 50, meaning tick_1ms strobes per one-LSB duty step.
REQ-002 SHALL have parameters TMR_P1/TMR_P2/TMR_P3, defaults 30/60/120, meaning sleep-timer presets in seconds (8-bit).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tick_1ms, input, 1, one-clk strobe every 1 ms.
REQ-006 SHALL have port tick_1s, input, 1, one-clk strobe every 1 s.
REQ-007 SHALL have port gear_req, input, 2, requested gear: 00 idle, 01 low, 10 mid, 11 high.
REQ-008 SHALL have port battery_empty, input, 1, level; battery depleted.
REQ-009 SHALL have port tmr_btn_press, input, 1, one-clk pulse; cycles the sleep-timer preset.
REQ-010 SHALL have port pwm_out, output, 1, motor drive.
REQ-011 SHALL have port duty, output, 5, current duty level 0..16.
REQ-012 SHALL have port ramp_busy, output, 1, high in RAMP_UP/RAMP_DOWN.
REQ-013 SHALL have port tmr_remain, output, 8, seconds left; 0 means timer off.
REQ-014 SHALL have port force_idle, output, 1, one-clk pulse on timer expiry, ORed by the integrator into the gear manager's forced-idle input.

Function
REQ-015 Target duty SHALL be gear 00->0, 01->6, 10->11, 11->16; target SHALL be 0 whenever battery_empty=1.
REQ-016 FSM states SHALL be IDLE (duty=0, target=0), RAMP_UP (duty<target), RAMP_DOWN (duty>target), RUN (duty=target>0).
REQ-017 A step counter SHALL increment on tick_1ms in a ramp state; on the tick where it equals RAMP_STEP_TICKS-1, duty SHALL change by exactly 1 toward target and the counter SHALL clear.
REQ-018 The step counter SHALL clear whenever target changes or duty equals target; a mid-ramp target change SHALL redirect the ramp from the current duty with no duty jump.
REQ-019 When duty reaches target, state SHALL become RUN (target>0) or IDLE (target=0) in the same cycle duty updates.
REQ-020 battery_empty=1 SHALL force duty=0, state IDLE, tmr_remain=0 on the next clk edge, bypassing the ramp; on release, restart SHALL be by normal RAMP_UP from 0.
REQ-021 PWM SHALL use a free-running 4-bit counter c; pwm_out = (c < duty) registered, so duty=16 is constant high and duty=0 constant low.
REQ-022 tmr_btn_press with gear_req!=00 and battery_empty=0 SHALL load the next preset in sequence off->P1->P2->P3->off; presses otherwise SHALL be ignored.
REQ-023 tmr_remain SHALL decrement by 1 on tick_1s while nonzero; on a tick where it equals 1, it SHALL go to 0, force_idle SHALL pulse one cycle, and target SHALL be 0 until gear_req returns to 00.
REQ-024 tmr_btn_press and tick_1s in the same cycle: press SHALL win (reload), decrement skipped, no force_idle.
REQ-025 gear_req=00 SHALL clear tmr_remain to 0 with no force_idle.

Reset
REQ-026 rst=1 SHALL set state IDLE, duty=0, pwm_out=0, ramp_busy=0, tmr_remain=0, force_idle=0, PWM and step counters 0, preset index off; rst asserted mid-ramp SHALL take effect on that edge.

Structure
REQ-027 Package fan_pkg SHALL hold gear encodings, duty table (0/6/11/16), FSM state enum and DUTY_MAX=16.
REQ-028 PWM counter and compare SHALL be sub-module fan_pwm_gen (inputs clk, rst, duty; output pwm_out).

Verification (RAMP_STEP_TICKS=4, TMR_P1=3)
REQ-029 gear_req 00->01 -> duty 0..6 one LSB per 4 tick_1ms, ramp_busy high for 24 ticks, then RUN.
REQ-030 At duty 8 ramping to 11, gear_req->01 -> RAMP_DOWN, duty 8,7,6, no jump, then RUN.
REQ-031 RUN duty 16, battery_empty=1 -> next edge duty=0, pwm_out=0, IDLE, tmr_remain=0.
REQ-032 gear 01 running, one tmr_btn_press -> tmr_remain 3,2,1,0 on tick_1s; force_idle one pulse; ramp down to 0 with gear_req still 01.
REQ-033 tmr_btn_press coincident with tick_1s at tmr_remain=1 -> tmr_remain=60 (P2), no force_idle.
REQ-034 duty 6 -> pwm_out high exactly 6 of every 16 clks; rst mid-ramp -> all outputs 0 next edge.

Source files
------------

// File: rtl/fan_pkg.sv
// fan_pkg: gear encodings, duty table and FSM states shared by the fan drive
package fan_pkg;
  localparam logic [1:0] GEAR_IDLE = 2'b00;
  localparam logic [1:0] GEAR_LOW = 2'b01;
  localparam logic [1:0] GEAR_MID = 2'b10;
  localparam logic [1:0] GEAR_HIGH = 2'b11;
  localparam logic [4:0] DUTY_LOW = 5'd6;
  localparam logic [4:0] DUTY_MID = 5'd11;
  localparam logic [4:0] DUTY_MAX = 5'd16;
  typedef enum logic [1:0] {ST_IDLE, ST_RAMP_UP, ST_RAMP_DOWN, ST_RUN} fan_state_e;
  function automatic logic [4:0] gear_duty(input logic [1:0] g);
    return g == GEAR_HIGH ? DUTY_MAX : g == GEAR_MID ? DUTY_MID : g == GEAR_LOW ? DUTY_LOW : 5'd0;
  endfunction
endpackage

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: 16-slot PWM; duty 16 is constant high, duty 0 constant low
module fan_pwm_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] duty,
  output logic       pwm_out
);
  logic [3:0] c_q, c_d;
  logic pwm_q, pwm_d;
  always_comb begin
    c_d = c_q + 4'd1;
    pwm_d = {1'b0, c_q} < duty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      c_q <= c_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_out = pwm_q;
endmodule

// File: rtl/fan_drive_sequencer.sv
// fan_drive_sequencer: ramped fan duty control with battery cutoff and sleep timer
module fan_drive_sequencer
  import fan_pkg::*;
#(
  parameter int         RAMP_STEP_TICKS = 50,
  parameter logic [7:0] TMR_P1 = 8'd30,
  parameter logic [7:0] TMR_P2 = 8'd60,
  parameter logic [7:0] TMR_P3 = 8'd120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       tick_1s,
  input  logic [1:0] gear_req,
  input  logic       battery_empty,
  input  logic       tmr_btn_press,
  output logic       pwm_out,
  output logic [4:0] duty,
  output logic       ramp_busy,
  output logic [7:0] tmr_remain,
  output logic       force_idle
);
  localparam int CW = $clog2(RAMP_STEP_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(RAMP_STEP_TICKS - 1);
  fan_state_e state_q, state_d;
  logic [4:0] duty_q, duty_d, target, target_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] idx_q, idx_d;
  logic busy_q, busy_d, fi_q, fi_d, expired_q, expired_d;
  logic ramping;
  always_comb begin
    ramping = state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN;
    target = (battery_empty || expired_q) ? 5'd0 : gear_duty(gear_req);
    duty_d = duty_q;
    cnt_d = cnt_q;
    if (battery_empty) begin
      duty_d = '0;
      cnt_d = '0;
    end else if (target != target_q || duty_q == target) begin
      cnt_d = '0;
    end else if (ramping && tick_1ms) begin
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      duty_d = cnt_q != LAST ? duty_q : duty_q < target ? duty_q + 5'd1 : duty_q - 5'd1;
    end
    state_d = duty_d == target ? (target == 5'd0 ? ST_IDLE : ST_RUN)
            : duty_d < target ? ST_RAMP_UP : ST_RAMP_DOWN;
    busy_d = state_d == ST_RAMP_UP || state_d == ST_RAMP_DOWN;
    // expiry holds the fan off until the user parks the gear at idle
    expired_d = expired_q && gear_req != GEAR_IDLE;
    idx_d = idx_q;
    tmr_d = tmr_q;
    fi_d = 1'b0;
    if (battery_empty || gear_req == GEAR_IDLE) begin
      idx_d = '0;
      tmr_d = '0;
    end else if (tmr_btn_press) begin
      idx_d = idx_q + 2'd1;
      tmr_d = idx_d == 2'd1 ? TMR_P1 : idx_d == 2'd2 ? TMR_P2 : idx_d == 2'd3 ? TMR_P3 : 8'd0;
    end else if (tick_1s && tmr_q != 8'd0) begin
      tmr_d = tmr_q - 8'd1;
      fi_d = tmr_q == 8'd1;
      expired_d = expired_d || tmr_q == 8'd1;
      idx_d = tmr_q == 8'd1 ? 2'd0 : idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q <= '0;
      target_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      fi_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      target_q <= target;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      fi_q <= fi_d;
      expired_q <= expired_d;
    end
  end
  fan_pwm_gen u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (duty_d),
    .pwm_out (pwm_out)
  );
  assign duty = duty_q;
  assign ramp_busy = busy_q;
  assign tmr_remain = tmr_q;
  assign force_idle = fi_q;
endmodule

// File: tb/tb_fan_drive_sequencer.sv
// tb_fan_drive_sequencer: vector table plus ramp/timer/battery/reset sequences
module tb_fan_drive_sequencer;
  logic clk = 1'b0, rst = 1'b1, tick_1ms = 1'b0, tick_1s = 1'b0;
  logic battery_empty = 1'b0, tmr_btn_press = 1'b0;
  logic [1:0] gear_req = 2'b00;
  logic pwm_out, ramp_busy, force_idle;
  logic [4:0] duty;
  logic [7:0] tmr_remain;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fan_drive_sequencer #(.RAMP_STEP_TICKS(4), .TMR_P1(8'd3), .TMR_P2(8'd60), .TMR_P3(8'd120)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .tick_1s(tick_1s), .gear_req(gear_req),
    .battery_empty(battery_empty), .tmr_btn_press(tmr_btn_press), .pwm_out(pwm_out),
    .duty(duty), .ramp_busy(ramp_busy), .tmr_remain(tmr_remain), .force_idle(force_idle)
  );
  typedef struct {
    logic [4:0] duty;
    logic busy;
    logic [7:0] tmr;
    logic fi;
    logic pwm;
    logic cp;
  } exp_t;
  typedef struct {
    logic r, t1ms, t1s;
    logic [1:0] g;
    logic bat, prs;
    logic [4:0] duty;
    logic busy;
    logic [7:0] tmr;
    logic fi, pwm, cp;
  } vec_t;
  exp_t sb[$];
  vec_t v[15];
  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask
  task automatic step(input logic r, t1ms, t1s, input logic [1:0] g, input logic bat, prs,
                      input logic [4:0] ed, input logic eb, input logic [7:0] et,
                      input logic ef, ep, cp, input string nm);
    exp_t e;
    rst = r; tick_1ms = t1ms; tick_1s = t1s; gear_req = g; battery_empty = bat; tmr_btn_press = prs;
    sb.push_back('{ed, eb, et, ef, ep, cp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({nm, " duty"}, duty, e.duty);
    cmp({nm, " ramp_busy"}, ramp_busy, e.busy);
    cmp({nm, " tmr_remain"}, tmr_remain, e.tmr);
    cmp({nm, " force_idle"}, force_idle, e.fi);
    if (e.cp) cmp({nm, " pwm_out"}, pwm_out, e.pwm);
    rst = 1'b0; tick_1ms = 1'b0; tick_1s = 1'b0; tmr_btn_press = 1'b0;
  endtask
  task automatic ramp(input logic [1:0] g, input int from, stop, tgt, input logic [7:0] t, input string nm);
    int d, nd;
    logic eb;
    d = from;
    while (d != stop) begin
      for (int k = 1; k <= 4; k++) begin
        nd = (k == 4) ? (d < stop ? d + 1 : d - 1) : d;
        eb = (k != 4) || (nd != tgt);
        step(0, 1, 0, g, 0, 0, 5'(nd), eb, t, 0, 0, 0, nm);
      end
      d = (d < stop) ? d + 1 : d - 1;
    end
  endtask
  initial begin
    int hi;
    //          r  1ms 1s  gear   bat prs duty busy tmr fi pwm cp
    v[0]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1};
    v[1]  = '{0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0};
    v[2]  = '{0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0};
    v[3]  = '{0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0};
    v[4]  = '{0, 1, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0};
    v[5]  = '{0, 1, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0};
    v[6]  = '{0, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0};
    v[7]  = '{0, 0, 0, 2'b01, 0, 1, 1, 1, 3, 0, 0, 0};
    v[8]  = '{0, 0, 1, 2'b01, 0, 0, 1, 1, 2, 0, 0, 0};
    v[9]  = '{0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0};
    v[10] = '{0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0};
    v[11] = '{0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0};
    v[12] = '{0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0};
    v[13] = '{0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1};
    v[14] = '{0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 15; i++)
      step(v[i].r, v[i].t1ms, v[i].t1s, v[i].g, v[i].bat, v[i].prs, v[i].duty, v[i].busy,
           v[i].tmr, v[i].fi, v[i].pwm, v[i].cp, $sformatf("vec%0d", i));
    // full ramp idle -> low, then PWM duty count
    step(0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, "up_start");
    ramp(2'b01, 0, 6, 6, 0, "ramp_up_low");
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      hi += int'(pwm_out);
    end
    cmp("pwm_high_of_16_at_duty6", hi, 6);
    // redirect mid-ramp at duty 8 toward 6
    step(0, 0, 0, 2'b10, 0, 0, 6, 1, 0, 0, 0, 0, "mid_start");
    ramp(2'b10, 6, 8, 11, 0, "ramp_to_8");
    step(0, 0, 0, 2'b01, 0, 0, 8, 1, 0, 0, 0, 0, "redirect");
    ramp(2'b01, 8, 6, 6, 0, "ramp_down_6");
    // sleep timer expiry
    step(0, 0, 0, 2'b01, 0, 1, 6, 0, 3, 0, 0, 0, "tmr_load");
    step(0, 0, 1, 2'b01, 0, 0, 6, 0, 2, 0, 0, 0, "tmr_2");
    step(0, 0, 1, 2'b01, 0, 0, 6, 0, 1, 0, 0, 0, "tmr_1");
    step(0, 0, 1, 2'b01, 0, 0, 6, 0, 0, 1, 0, 0, "tmr_expire");
    step(0, 0, 0, 2'b01, 0, 0, 6, 1, 0, 0, 0, 0, "post_expire");
    ramp(2'b01, 6, 0, 0, 0, "expire_ramp_down");
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, "park_idle");
    step(0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0, 0, "restart_low");
    // press coincident with last second
    step(0, 0, 0, 2'b01, 0, 1, 0, 1, 3, 0, 0, 0, "p_load");
    step(0, 0, 1, 2'b01, 0, 0, 0, 1, 2, 0, 0, 0, "p_2");
    step(0, 0, 1, 2'b01, 0, 0, 0, 1, 1, 0, 0, 0, "p_1");
    step(0, 0, 1, 2'b01, 0, 1, 0, 1, 60, 0, 0, 0, "press_wins");
    step(0, 0, 0, 2'b01, 0, 0, 0, 1, 60, 0, 0, 0, "p2_hold");
    step(0, 0, 1, 2'b01, 0, 0, 0, 1, 59, 0, 0, 0, "p2_dec");
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, "gear0_clears");
    // battery cutoff from full speed
    step(0, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, "high_start");
    ramp(2'b11, 0, 16, 16, 0, "ramp_up_high");
    step(0, 0, 0, 2'b11, 0, 0, 16, 0, 0, 0, 1, 1, "full_pwm");
    step(0, 0, 0, 2'b11, 0, 1, 16, 0, 3, 0, 1, 1, "high_tmr");
    step(0, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 1, "battery_cut");
    step(0, 0, 0, 2'b11, 1, 1, 0, 0, 0, 0, 0, 1, "battery_press");
    step(0, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, "battery_release");
    // reset mid-ramp
    ramp(2'b11, 0, 2, 16, 0, "ramp_pre_rst");
    step(0, 0, 0, 2'b11, 0, 1, 2, 1, 3, 0, 0, 0, "rst_tmr");
    step(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, "rst_mid_ramp");
    step(0, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
